// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide controller.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MULTU = 2'b00,
    MULT  = 2'b01,
    DIVU  = 2'b10,
    DIV   = 2'b11
  } muldiv_op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } muldiv_state_t;

  localparam int MULDIV_ITERS = 32;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply ({P,M}) or restoring divide ({R,Q}).
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               div_mode_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   operand_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;

  always_comb begin
    // Multiply: conditionally add the multiplicand into P, then shift {carry,P,M} right.
    mul_sum = acc_i[0] ? ({1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, operand_i})
                       : {1'b0, acc_i[2*WIDTH-1:WIDTH]};

    // Divide: the shifted remainder needs one extra bit since it may exceed WIDTH bits.
    rem_shift = acc_i[2*WIDTH-1:WIDTH-1];
    trial     = rem_shift - {1'b0, operand_i};

    if (div_mode_i) begin
      if (!trial[WIDTH]) begin
        acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {rem_shift[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {mul_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller holding the HI/LO registers.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(MULDIV_ITERS);
  localparam logic [CW-1:0] LAST_CNT = CW'(MULDIV_ITERS - 1);

  muldiv_state_t      state_q, state_d;
  muldiv_op_t         op_q, op_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic               dz_q, dz_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [2*WIDTH-1:0] step_acc;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quot_neg, rem_neg;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode_i (state_q == S_DIV),
    .acc_i      (acc_q),
    .operand_i  (opnd_q),
    .acc_o      (step_acc)
  );

  always_comb begin
    // Magnitudes only for signed ops; 0x80000000 maps to itself and is read as unsigned.
    abs_a    = (op[0] && a[WIDTH-1]) ? -a : a;
    abs_b    = (op[0] && b[WIDTH-1]) ? -b : b;
    prod_neg = -acc_q;
    quot_neg = -acc_q[WIDTH-1:0];
    rem_neg  = -acc_q[2*WIDTH-1:WIDTH];

    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = muldiv_op_t'(op);
          sa_d  = op[0] & a[WIDTH-1];
          sb_d  = op[0] & b[WIDTH-1];
          cnt_d = '0;
          dz_d  = 1'b0;
          if (op[1]) begin
            if (b == '0) begin
              dz_d    = 1'b1;
              state_d = S_DONE;
            end else begin
              acc_d   = {{WIDTH{1'b0}}, abs_a};
              opnd_d  = abs_b;
              state_d = S_DIV;
            end
          end else begin
            acc_d   = {{WIDTH{1'b0}}, abs_b};
            opnd_d  = abs_a;
            state_d = S_MUL;
          end
        end else begin
          if (hi_wr) hi_d = wr_data;
          if (lo_wr) lo_d = wr_data;
        end
      end

      S_MUL, S_DIV: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = S_FIX;
      end

      S_FIX: begin
        if (op_q[1]) begin
          lo_d = (sa_q ^ sb_q) ? quot_neg : acc_q[WIDTH-1:0];
          hi_d = sa_q ? rem_neg : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = (sa_q ^ sb_q) ? prod_neg : acc_q;
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= MULTU;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy        = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = (state_q == S_DONE) && dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomised and directed bench for muldiv_ctrl against a plain-arithmetic HI/LO model.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        hi_wr, lo_wr;
  logic [31:0] wr_data;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .hi_wr       (hi_wr),
    .lo_wr       (lo_wr),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  // Reference: architectural result from 64-bit arithmetic.
  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] eh, output logic [31:0] el, output bit dz);
    logic [63:0] p;
    longint sx, sy, q, r;
    dz = 0; eh = model_hi; el = model_lo;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin p = {32'b0, x} * {32'b0, y}; eh = p[63:32]; el = p[31:0]; end
      2'b01: begin p = sx * sy; eh = p[63:32]; el = p[31:0]; end
      2'b10: if (y == 0) dz = 1; else begin el = x / y; eh = x % y; end
      default: if (y == 0) dz = 1;
               else begin
                 q = sx / sy; r = sx % sy;
                 p = q; el = p[31:0];
                 p = r; eh = p[31:0];
               end
    endcase
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input string name, input int inj_start, input int inj_hiwr,
                        input bit wr_with_start);
    logic [31:0] eh, el;
    bit dz;
    int last;
    model(o, x, y, eh, el, dz);
    last = dz ? 1 : 34;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    if (wr_with_start) begin hi_wr = 1'b1; lo_wr = 1'b1; wr_data = $urandom; end
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      start = (k == inj_start); hi_wr = (k == inj_hiwr); lo_wr = 1'b0;
      wr_data = $urandom; op = 2'($urandom); a = $urandom; b = $urandom;
      total++;
      if (busy !== (k < last)) begin
        bad++; $display("FAIL %s busy cycle %0d: got %b want %b", name, k, busy, k < last);
      end
      total++;
      if (done !== (k == last)) begin
        bad++; $display("FAIL %s done cycle %0d: got %b want %b", name, k, done, k == last);
      end
      if (k == last - 1) begin
        total++;
        if (hi !== model_hi || lo !== model_lo) begin
          bad++; $display("FAIL %s early write: got %h_%h want %h_%h", name, hi, lo, model_hi, model_lo);
        end
      end
    end
    total++;
    if (hi !== eh || lo !== el || div_by_zero !== dz) begin
      bad++;
      $display("FAIL %s result: got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
               name, hi, lo, div_by_zero, eh, el, dz);
    end
    $display("op %s op=%0d a=%h b=%h -> hi=%h lo=%h dz=%b", name, o, x, y, hi, lo, div_by_zero);
    start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    model_hi = eh; model_lo = el;
  endtask

  task automatic write_hilo(input logic [31:0] hv, input logic [31:0] lv);
    @(negedge clk); hi_wr = 1'b1; wr_data = hv;
    @(negedge clk); hi_wr = 1'b0; lo_wr = 1'b1; wr_data = lv;
    @(negedge clk); lo_wr = 1'b0;
    model_hi = hv; model_lo = lv;
    total++;
    if (hi !== hv || lo !== lv) begin
      bad++; $display("FAIL mthi_mtlo: got %h_%h want %h_%h", hi, lo, hv, lv);
    end
    $display("mthi/mtlo hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    hi_wr = 1'b0; lo_wr = 1'b0; wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      bad++; $display("FAIL reset: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
                      busy, done, div_by_zero, hi, lo);
    end
    $display("reset busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    reset = 1'b0;
    model_hi = '0; model_lo = '0;
  endtask

  task automatic test_directed();
    run_op(2'b00, 32'hFFFFFFFF, 32'd2, "multu_max", -1, -1, 0);
    run_op(2'b01, 32'hFFFFFFFD, 32'd5, "mult_neg", -1, -1, 0);
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, "div_neg", -1, -1, 0);
    run_op(2'b10, 32'd100, 32'd7, "divu_100_7", -1, -1, 0);
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, "div_wrap", -1, -1, 0);
    run_op(2'b01, 32'h80000000, 32'h80000000, "mult_minmin", -1, -1, 0);
  endtask

  task automatic test_div_by_zero();
    write_hilo(32'hA5A5A5A5, 32'h5A5A5A5A);
    run_op(2'b10, 32'd5, 32'd0, "divu_by_zero", -1, -1, 0);
    run_op(2'b11, 32'hFFFFFFF0, 32'd0, "div_by_zero", -1, -1, 0);
  endtask

  task automatic test_mid_op();
    run_op(2'b01, 32'h12345678, 32'hFEDCBA98, "mult_ignore_start_hiwr", 5, 10, 0);
    run_op(2'b10, 32'hDEADBEEF, 32'h00001234, "divu_start_wins_wr", -1, -1, 1);
  endtask

  task automatic test_reset_mid_op();
    int seen_done;
    @(negedge clk);
    op = 2'b01; a = 32'hFFFF0001; b = 32'h00070003; start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 12) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      bad++; $display("FAIL reset_mid_op: got busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
                      busy, done, hi, lo);
    end
    seen_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    total++;
    if (seen_done != 0) begin
      bad++; $display("FAIL reset_no_done: got %0d active cycles want 0", seen_done);
    end
    $display("reset mid-op hi=%h lo=%h", hi, lo);
    model_hi = '0; model_lo = '0;
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    logic [1:0]  o;
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom);
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 9));
        2: x = 32'h80000000;
        3: y = 32'hFFFFFFFF;
        default: ;
      endcase
      if ($urandom_range(0, 5) == 0) write_hilo($urandom, $urandom);
      run_op(o, x, y, "random", -1, -1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_by_zero();
    test_mid_op();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide controller for the MIPS core. It handles MULT, MULTU, DIV and DIVU through an iterative shift-add / restoring-divide datapath and holds the HI/LO architectural registers. The combinational ALU is then left with single-cycle operations only. The pipeline issues operations through a start/busy/done handshake and stalls on `busy`.

## Interface
- `WIDTH`, 32, operand and HI/LO width
- `clk`  in  1  rising-edge clock, sole clock domain
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request a new operation; sampled only in IDLE
- `op`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- `a`  in  WIDTH  multiplicand / dividend (rs)
- `b`  in  WIDTH  multiplier / divisor (rt)
- `hi_wr`  in  1  MTHI: write `wr_data` to HI
- `lo_wr`  in  1  MTLO: write `wr_data` to LO
- `wr_data`  in  WIDTH  data for MTHI/MTLO
- `busy`  out  1  operation in flight; pipeline stalls MFHI/MFLO/new muldiv
- `done`  out  1  one-cycle pulse: HI/LO updated
- `div_by_zero`  out  1  qualifies `done`: divide with `b == 0`
- `hi`  out  WIDTH  HI register (product high / remainder)
- `lo`  out  WIDTH  LO register (product low / quotient)

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE + `start`:
  - Latch `op`.
  - Signed ops (MULT, DIV): store |a| and |b|, sign flags `sa`/`sb`.
  - Unsigned ops: store raw operands.
  - Clear the 5-bit iteration counter.
  - Go to MUL (op[1]=0) or DIV (op[1]=1).
  - Exception: DIV/DIVU with `b == 0` goes straight to DONE.
- MUL, one step per cycle over 32 cycles: 64-bit accumulator {P,M}.
  - If M[0], add the multiplicand to P[WIDTH:0].
  - Shift {carry,P,M} right by 1.
  - After count 31 → FIX.
- DIV, restoring, 32 cycles: shift {R,Q} left by 1, trial R−divisor.
  - If the trial is non-negative, R = trial and Q[0] = 1.
  - After count 31 → FIX.
- FIX: apply signs.
  - MULT: negate the 64-bit product (two's complement) if `sa^sb`.
  - DIV: negate the quotient if `sa^sb`; negate the remainder if `sa`.
  - Unsigned ops pass through.
  - Write HI/LO → DONE.
- DONE: `done` = 1 for this single cycle → IDLE.
- Divide by zero: HI/LO unchanged; `done` and `div_by_zero` both high in DONE.
- Width rules: all arithmetic is modulo 2^WIDTH per half.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (wraps, no trap).
  - Magnitude of 0x80000000 is 0x80000000 treated as unsigned.
- `hi_wr`/`lo_wr`: honoured only in IDLE when `start` is low.
  - Ignored in all other states.
  - `start` + `hi_wr` in the same IDLE cycle: start wins, write dropped.
- `start` outside IDLE is ignored (no queueing).
- `op`/`a`/`b` are don't-care except in the accepting cycle.

## Timing
- Reset values: state IDLE, `hi` = `lo` = 0, `busy` = 0, `done` = 0, `div_by_zero` = 0, counter 0.
- Reset mid-operation: next cycle is IDLE with the reset values above. The partial result is discarded; no `done`.
- Cycle numbering: `start` sampled at edge 0.
  - Cycles 1–32: iterations.
  - Cycle 33: FIX.
  - Cycle 34: DONE (`done` = 1, new HI/LO visible).
  - Cycle 35: IDLE, which accepts the next start.
- Divide by zero: DONE in cycle 1, IDLE in cycle 2.
- `busy` = 1 in MUL, DIV and FIX; 0 in IDLE and DONE.
- `busy` is registered state decode, with no combinational path from `start`.
- MTHI/MTLO: HI/LO updated at the edge after `hi_wr`/`lo_wr`.
- All outputs are registered or pure state decode.

## Structure
- Package `muldiv_pkg`:
  - `muldiv_op_t` enum: MULTU, MULT, DIVU, DIV.
  - `muldiv_state_t` enum.
  - `MULDIV_ITERS` = 32.
- Sub-module `muldiv_step`: combinational single iteration.
  - Inputs: mode, {P,M} or {R,Q}, operand.
  - Output: the next accumulator.
- The FSM, counter, sign flags and HI/LO stay in `muldiv_ctrl`.

## Test plan
- MULTU a=0xFFFFFFFF, b=2 → cycle 34: `done`, HI=0x00000001, LO=0xFFFFFFFE; `busy` high cycles 1–33.
- MULT a=0xFFFFFFFD (−3), b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 → LO=14, HI=2.
- Preload via MTHI/MTLO (0xA5A5A5A5 / 0x5A5A5A5A), then DIVU 5/0 → `done` and `div_by_zero` in cycle 1, HI/LO unchanged.
- Mid-operation events during a MULT:
  - `start` at cycle 5 ignored.
  - `hi_wr` at cycle 10 ignored.
  - Result unchanged.
  - Repeat with `reset` at cycle 12 → IDLE, HI=LO=0, no `done`.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0, `div_by_zero`=0.
